// File: rtl/redundant_to_binary_adder_if.sv
// Handshake bundle between the compressor tree, the redundant-to-binary adder and its consumer.
// The master side drives operands and out_ready; the slave side is the adder itself.
interface redundant_to_binary_adder_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_sum;
   logic [WIDTH-1:0] in_carry;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH+1:0] out_result;

   modport master (
      output in_valid, in_sum, in_carry, out_ready,
      input  in_ready, out_valid, out_result
   );

   modport slave (
      input  in_valid, in_sum, in_carry, out_ready,
      output in_ready, out_valid, out_result
   );
endinterface

// File: rtl/redundant_to_binary_adder.sv
// Pipelined carry-propagate adder collapsing a (sum, carry) redundant pair into binary,
// resolving CHUNK bits per stage with the inter-chunk carry registered between stages.
module redundant_to_binary_adder #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic                        clk,
   input  logic                        rst,
   redundant_to_binary_adder_if.slave  bus
);
   localparam int STAGES = WIDTH / CHUNK;
   localparam int RW     = WIDTH + 2;

   // Slot 0 captures the raw operands; slot s+1 holds the output of compute stage s.
   logic            adv;
   logic [STAGES:0] valid_q, valid_d;
   logic [STAGES:0] carry_q, carry_d;
   logic [RW-1:0]   a_q   [STAGES+1];
   logic [RW-1:0]   a_d   [STAGES+1];
   logic [RW-1:0]   b_q   [STAGES+1];
   logic [RW-1:0]   b_d   [STAGES+1];
   logic [RW-1:0]   res_q [STAGES+1];
   logic [RW-1:0]   res_d [STAGES+1];
   logic [CHUNK:0]  chunkSum [STAGES];

   assign adv            = bus.out_ready | ~bus.out_valid;
   assign bus.in_ready   = adv;
   assign bus.out_valid  = valid_q[STAGES];
   assign bus.out_result = res_q[STAGES];

   always_comb begin
      valid_d  = {valid_q[STAGES-1:0], bus.in_valid & adv};
      carry_d  = '0;
      a_d[0]   = {2'b00, bus.in_sum};
      b_d[0]   = {1'b0, bus.in_carry, 1'b0};
      res_d[0] = '0;
      for (int s = 0; s < STAGES; s++) begin
         chunkSum[s] = {1'b0, a_q[s][s*CHUNK +: CHUNK]}
                     + {1'b0, b_q[s][s*CHUNK +: CHUNK]}
                     + {{CHUNK{1'b0}}, (s == 0) ? 1'b0 : carry_q[s]};
         a_d[s+1]   = a_q[s];
         b_d[s+1]   = b_q[s];
         res_d[s+1] = res_q[s];
         res_d[s+1][s*CHUNK +: CHUNK] = chunkSum[s][CHUNK-1:0];
         if (s < STAGES - 1) begin
            carry_d[s+1] = chunkSum[s][CHUNK];
         end
      end
      // The top two result bits take the shifted-out carry MSB plus the final chunk carry.
      res_d[STAGES][RW-1:WIDTH] = {1'b0, b_q[STAGES-1][WIDTH]}
                                + {1'b0, chunkSum[STAGES-1][CHUNK]};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
         carry_q <= '0;
         for (int s = 0; s <= STAGES; s++) begin
            a_q[s]   <= '0;
            b_q[s]   <= '0;
            res_q[s] <= '0;
         end
      end else if (adv) begin
         valid_q <= valid_d;
         carry_q <= carry_d;
         for (int s = 0; s <= STAGES; s++) begin
            a_q[s]   <= a_d[s];
            b_q[s]   <= b_d[s];
            res_q[s] <= res_d[s];
         end
      end
   end
endmodule

// File: tb/tb_redundant_to_binary_adder.sv
// Directed-vector bench for redundant_to_binary_adder: reset, carry ripple, extremes,
// streaming, backpressure and mid-flight reset, with a FIFO scoreboard of hand-computed results.
module tb_redundant_to_binary_adder;
   localparam int WIDTH = 32;
   localparam int CHUNK = 8;
   localparam int RW    = WIDTH + 2;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   redundant_to_binary_adder_if #(.WIDTH(WIDTH)) bus ();

   redundant_to_binary_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [WIDTH-1:0] vSum   [11] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001,
                                     32'h12345678, 32'h000000FF, 32'h0000FFFF, 32'hFFFFFFFE,
                                     32'h0F0F0F0F, 32'hAAAAAAAA, 32'h00FF00FF};
   logic [WIDTH-1:0] vCarry [11] = '{32'h00000001, 32'hFFFFFFFF, 32'h80000000, 32'h00000001,
                                     32'h00000000, 32'h00000080, 32'h00008000, 32'h00000001,
                                     32'h01010101, 32'h55555555, 32'h7F807F80};
   logic [RW-1:0]    vExp   [11] = '{34'h100000001, 34'h2FFFFFFFD, 34'h100000000, 34'h000000003,
                                     34'h012345678, 34'h0000001FF, 34'h00001FFFF, 34'h100000000,
                                     34'h011111111, 34'h155555554, 34'h0FFFFFFFF};

   int            compareCount  = 0;
   int            mismatchCount = 0;
   int            cycle         = 0;
   int            outCount      = 0;
   bit            checkLatency  = 1'b1;
   logic [RW-1:0] expQ [$];
   int            accQ [$];

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      compareCount++;
      if (observed !== expected) begin
         mismatchCount++;
         $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Called at a falling edge; drives one cycle, scores any output transfer and returns at the next falling edge.
   task automatic applyStimulus(input bit inV, input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] c,
                                input logic [RW-1:0] e, input bit outR, output bit accepted);
      logic [RW-1:0] expVal;
      int            accCycle;
      bus.in_valid  = inV;
      bus.in_sum    = s;
      bus.in_carry  = c;
      bus.out_ready = outR;
      #1;
      accepted = inV & bus.in_ready & ~rst;
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1 && !rst) begin
         if (expQ.size() == 0) begin
            checkOutput("spurious_out_valid", {63'd0, bus.out_valid}, 64'd0);
         end else begin
            expVal   = expQ.pop_front();
            accCycle = accQ.pop_front();
            outCount++;
            checkOutput("result", {30'd0, bus.out_result}, {30'd0, expVal});
            if (checkLatency) checkOutput("latency", 64'(cycle - accCycle), 64'd5);
         end
      end
      if (accepted) begin
         expQ.push_back(e);
         accQ.push_back(cycle);
      end
      @(posedge clk);
      cycle++;
      @(negedge clk);
   endtask

   task automatic sendOne(input int idx);
      bit acc;
      int n;
      acc = 1'b0;
      n   = 0;
      while (!acc && n < 20) begin
         applyStimulus(1'b1, vSum[idx], vCarry[idx], vExp[idx], 1'b1, acc);
         n++;
      end
      checkOutput("send_accepted", {63'd0, acc}, 64'd1);
   endtask

   task automatic drain(input string tag);
      bit acc;
      int n;
      n = 0;
      while (expQ.size() > 0 && n < 40) begin
         applyStimulus(1'b0, '0, '0, '0, 1'b1, acc);
         n++;
      end
      checkOutput(tag, 64'(expQ.size()), 64'd0);
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bit            acc;
      bit            seenValid;
      int            ptr;
      int            idx;
      int            n;
      int            held;
      int            startCount;
      logic [RW-1:0] holdVal;

      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_sum    = '0;
      bus.in_carry  = '0;
      bus.out_ready = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 2; i++) begin
         applyStimulus(1'b1, $urandom, $urandom, '0, 1'($urandom_range(0, 1)), acc);
      end
      checkOutput("reset_out_valid", {63'd0, bus.out_valid}, 64'd0);
      checkOutput("reset_out_result", {30'd0, bus.out_result}, 64'd0);
      checkOutput("reset_in_ready", {63'd0, bus.in_ready}, 64'd1);
      rst = 1'b0;

      seenValid = 1'b0;
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b0, $urandom, $urandom, '0, 1'b1, acc);
         seenValid |= bus.out_valid;
      end
      checkOutput("idle_no_output", {63'd0, seenValid}, 64'd0);

      // Cross-chunk ripple and the two extreme values, each in isolation.
      for (int i = 0; i < 3; i++) begin
         sendOne(i);
         drain("directed_drain");
      end

      startCount = outCount;
      ptr = 0;
      n   = 0;
      while ((ptr < 8 || expQ.size() > 0) && n < 60) begin
         idx = (ptr < 8) ? 3 + ptr : 3;
         applyStimulus(ptr < 8, vSum[idx], vCarry[idx], vExp[idx], 1'b1, acc);
         if (ptr < 8) checkOutput("stream_accept", {63'd0, acc}, 64'd1);
         if (acc) ptr++;
         n++;
      end
      checkOutput("stream_count", 64'(outCount - startCount), 64'd8);

      // Fill the pipe against a stalled consumer, hold for three cycles, then release.
      checkLatency = 1'b0;
      startCount   = outCount;
      ptr  = 0;
      n    = 0;
      held = 0;
      while ((ptr < 8 || expQ.size() > 0) && n < 80) begin
         if (bus.out_valid === 1'b1 && held < 3) begin
            bus.out_ready = 1'b0;
            #1;
            if (held == 0) begin
               holdVal = bus.out_result;
               checkOutput("bp_pipe_full", 64'(ptr), 64'd5);
            end else begin
               checkOutput("bp_stable", {30'd0, bus.out_result}, {30'd0, holdVal});
            end
            checkOutput("bp_in_ready", {63'd0, bus.in_ready}, 64'd0);
            held++;
         end
         idx = (ptr < 8) ? 3 + ptr : 3;
         applyStimulus(ptr < 8, vSum[idx], vCarry[idx], vExp[idx], held >= 3, acc);
         if (acc) ptr++;
         n++;
      end
      checkOutput("bp_count", 64'(outCount - startCount), 64'd8);
      checkLatency = 1'b1;

      // Two operands in flight, then a one-cycle reset must discard both.
      applyStimulus(1'b1, vSum[0], vCarry[0], vExp[0], 1'b1, acc);
      checkOutput("mid_accept0", {63'd0, acc}, 64'd1);
      applyStimulus(1'b1, vSum[1], vCarry[1], vExp[1], 1'b1, acc);
      checkOutput("mid_accept1", {63'd0, acc}, 64'd1);
      applyStimulus(1'b0, '0, '0, '0, 1'b1, acc);
      rst = 1'b1;
      applyStimulus(1'b0, '0, '0, '0, 1'b1, acc);
      rst = 1'b0;
      expQ.delete();
      accQ.delete();
      checkOutput("mid_reset_out_valid", {63'd0, bus.out_valid}, 64'd0);
      seenValid = 1'b0;
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b0, '0, '0, '0, 1'b1, acc);
         seenValid |= bus.out_valid;
      end
      checkOutput("mid_reset_no_stale", {63'd0, seenValid}, 64'd0);

      sendOne(9);
      drain("post_reset_drain");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end
endmodule

// File: doc/redundant_to_binary_adder.md
# redundant_to_binary_adder

Pipelined carry-propagate adder that resolves the redundant (sum, carry) vector pair produced by a 4:2 compressor tree into a single binary result. It sits directly downstream of the compressor array in the multiplier/multi-operand-adder datapath. It splits the carry chain into CHUNK-bit segments, one per pipeline stage, so long operands close timing. Valid/ready handshakes are on both sides.

## Interface
Parameters:
- WIDTH, 32: bit width of each redundant input vector; must be a multiple of CHUNK.
- CHUNK, 8: bits resolved per pipeline stage. STAGES = WIDTH/CHUNK (derived, not overridable).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream presents an operand pair.
- in_ready  output  1  block can accept this cycle.
- in_sum  input  WIDTH  compressor sum vector, weight 2^i for bit i.
- in_carry  input  WIDTH  compressor carry vector, weight 2^(i+1) for bit i.
- out_valid  output  1  out_result holds a valid result.
- out_ready  input  1  downstream accepts this cycle.
- out_result  output  WIDTH+2  exact in_sum + (in_carry << 1); never truncated.

## Operation
- Arithmetic: A = {2'b0, in_sum}, B = {1'b0, in_carry, 1'b0}, out_result = A + B. The worst case, (2^WIDTH−1)·3, fits in WIDTH+2 bits.
- Stage s (0..STAGES−1) adds A/B bits [s·CHUNK +: CHUNK] plus the carry registered by stage s−1. Stage 0 has carry-in 0.
- The last stage also folds B[WIDTH] and its own carry-out into out_result[WIDTH+1:WIDTH].
- Operand bits not yet consumed travel skewed in the pipeline registers. Result chunks already computed travel alongside them to the output.
- Each stage holds a valid bit. There is one global advance enable: adv = out_ready | ~out_valid.
- When adv = 1, every stage shifts forward one position, and stage 0 loads the input when in_valid & in_ready.
- When adv = 0, every register holds its value.
- in_ready = adv, a combinational function of out_ready and out_valid. No combinational path exists from in_valid to in_ready.
- Bubbles are not compressed. An empty stage moves forward as an invalid slot.
- Ordering is strictly FIFO. Results are never dropped or duplicated.
- A transfer occurs on a side only when valid & ready are both high at a clock edge.

## Timing
- Latency: an operand accepted at edge k produces out_valid = 1 after edge k+STAGES, provided adv stays 1 (4 cycles for the defaults). Each stalled cycle adds one cycle.
- Throughput: one result per cycle when out_ready is held high.
- Reset (rst = 1 at an edge) clears all valid bits, carry registers, data registers and out_result to 0. The pipeline flushes in a single cycle.
- Reset values: out_valid = 0, out_result = 0, in_ready = 1 (because out_valid = 0).
- Reset mid-operation discards all in-flight operands. No stale result ever appears after reset is released.
- rst has priority over in_valid and out_ready in the same cycle.
- out_valid is held with backpressure: while out_valid = 1 and out_ready = 0, out_result is stable and in_ready = 0.
- Input held with in_ready low: an input presented while in_ready = 0 is not consumed. The upstream block must hold it.
- Simultaneous accept and emit (full pipe, out_ready = 1, in_valid = 1) both occur in the same cycle with no bubble.
- Carry across a chunk boundary: a carry generated in stage s is used only by stage s+1 in the following cycle. It never reaches the final result combinationally.

## Test plan
- Reset: hold rst = 1 for 2 cycles with random inputs -> out_valid = 0, out_result = 0, in_ready = 1; no output for 10 cycles with in_valid = 0.
- Cross-chunk carry ripple (defaults): in_sum = 0xFFFFFFFF, in_carry = 0x00000001 accepted at edge k -> out_result = 0x100000001 with out_valid first high after edge k+4.
- Maximum value: in_sum = in_carry = 0xFFFFFFFF -> out_result = 0x2FFFFFFFD (34 bits); also in_sum = 0, in_carry = 0x80000000 -> 0x100000000.
- Streaming: 8 back-to-back random pairs, in_valid = out_ready = 1 -> 8 consecutive out_valid cycles, results in order and matching the reference model.
- Backpressure: drop out_ready for 3 cycles while out_valid = 1 with the pipe full -> out_result stable, in_ready = 0, and after release every operand emerges exactly once in order.
- Mid-flight reset: accept 2 operands, assert rst for 1 cycle 2 cycles later -> out_valid = 0 after that edge and no result from the flushed operands ever appears.
